// File: rtl/bitwise_op_pipe.sv
// Bitwise XOR/XNOR/AND/OR with a combinational tap and a DEPTH-stage valid/ready pipeline.
// Define BITWISE_OP_PIPE_ACCUM_EN to build the XOR accumulator on accepted output beats.
module bitwise_op_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] acc_out
);

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_XNOR = 2'b01,
    OP_AND  = 2'b10,
    OP_OR   = 2'b11
  } op_e;

  logic [WIDTH-1:0] w_comb;
  logic             w_advance;
  logic             w_accept_in;
  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];

  always_comb begin
    w_comb = '0;
    case (op_e'(op))
      OP_XOR:  w_comb = a ^ b;
      OP_XNOR: w_comb = ~(a ^ b);
      OP_AND:  w_comb = a & b;
      OP_OR:   w_comb = a | b;
      default: w_comb = '0;
    endcase
  end

  assign out_comb    = w_comb;
  assign out_valid   = r_vld[DEPTH-1];
  assign out_data    = r_dat[DEPTH-1];
  // Whole pipe moves as one shift register; bubbles are kept, never collapsed.
  assign w_advance   = !r_vld[DEPTH-1] || out_ready;
  assign in_ready    = w_advance;
  assign w_accept_in = in_valid && w_advance;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else if (w_advance) begin
      r_vld[0] <= w_accept_in;
      r_dat[0] <= w_accept_in ? w_comb : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

`ifdef BITWISE_OP_PIPE_ACCUM_EN
  logic             w_accept_out;
  logic [WIDTH-1:0] r_acc;

  assign w_accept_out = r_vld[DEPTH-1] && out_ready;

  // Clear and accept together: the cleared value is folded with this beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (w_accept_out) begin
      r_acc <= (acc_clr ? '0 : r_acc) ^ r_dat[DEPTH-1];
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign acc_out = r_acc;
`else
  logic w_unused_acc_clr;

  assign w_unused_acc_clr = acc_clr;
  assign acc_out          = '0;
`endif

endmodule

// File: tb/tb_bitwise_op_pipe.sv
// Directed and randomized checks of bitwise_op_pipe at WIDTH=8, DEPTH=2.
module tb_bitwise_op_pipe;

`ifdef BITWISE_OP_PIPE_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_comb;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       acc_clr;
  logic [7:0] acc_out;

  int tests;
  int fails;

  bitwise_op_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .a        (a),
    .b        (b),
    .op       (op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_comb (out_comb),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_clr  (acc_clr),
    .acc_out  (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'b00:   return x ^ y;
      2'b01:   return ~(x ^ y);
      2'b10:   return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic logic [7:0] acc_exp(input logic [7:0] v);
    return ACC_EN ? v : 8'h00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    a = 8'h00; b = 8'h00; op = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic beat(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; a = 8'h0F; b = 8'h3C; op = 2'b00; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    #1;
    tests++; if (out_comb !== 8'h33) begin fails++; $display("FAIL rst_comb got=%h exp=33", out_comb); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_ovalid got=%b exp=0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_odata got=%h exp=00", out_data); end
    tests++; if (acc_out !== 8'h00) begin fails++; $display("FAIL rst_acc got=%h exp=00", acc_out); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_iready got=%b exp=1", in_ready); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_iready got=%b exp=1", in_ready); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      fails++; $display("FAIL rel_idle got=%b/%h exp=0/00", out_valid, out_data);
    end
  endtask

  task automatic test_comb();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] ve [4];
    va = '{8'hF0, 8'hAA, 8'hF0, 8'h00};
    vb = '{8'h3C, 8'h55, 8'h3C, 8'h00};
    ve = '{8'hCC, 8'h00, 8'h30, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op = 2'(i); a = va[i]; b = vb[i]; in_valid = 1'b0;
      #1;
      tests++; if (out_comb !== ve[i]) begin
        fails++; $display("FAIL comb_op%0d got=%h exp=%h", i, out_comb, ve[i]);
      end
    end
  endtask

  task automatic test_latency();
    do_reset();
    beat(2'b00, 8'h0F, 8'h3C);
    beat(2'b00, 8'hFF, 8'h01);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_n1_valid got=%b exp=0", out_valid); end
    @(negedge clk); in_valid = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      fails++; $display("FAIL lat_n2 got=%b/%h exp=1/33", out_valid, out_data);
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin
      fails++; $display("FAIL lat_n3 got=%b/%h exp=1/fe", out_valid, out_data);
    end
    tests++; if (acc_out !== acc_exp(8'h33)) begin fails++; $display("FAIL lat_acc1 got=%h exp=%h", acc_out, acc_exp(8'h33)); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_n4_valid got=%b exp=0", out_valid); end
    tests++; if (acc_out !== acc_exp(8'hCD)) begin fails++; $display("FAIL lat_acc2 got=%h exp=%h", acc_out, acc_exp(8'hCD)); end
  endtask

  task automatic test_stall();
    do_reset();
    beat(2'b10, 8'hF0, 8'h3C);
    beat(2'b11, 8'hF0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h30 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/30/0", i, out_valid, out_data, in_ready);
      end
    end
    tests++; if (acc_out !== 8'h00) begin fails++; $display("FAIL stall_acc got=%h exp=00", acc_out); end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h30 || in_ready !== 1'b1) begin
      fails++; $display("FAIL stall_rel got=%b/%h/%b exp=1/30/1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_data !== 8'hFC) begin
      fails++; $display("FAIL stall_2nd got=%b/%h exp=1/fc", out_valid, out_data);
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_end got=%b exp=0", out_valid); end
    tests++; if (acc_out !== acc_exp(8'hCC)) begin fails++; $display("FAIL stall_accend got=%h exp=%h", acc_out, acc_exp(8'hCC)); end
  endtask

  task automatic test_acc_clr();
    do_reset();
    beat(2'b00, 8'hAA, 8'h00);
    beat(2'b00, 8'h55, 8'h00);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    tests++; if (acc_out !== acc_exp(8'hAA) || out_data !== 8'h55 || out_valid !== 1'b1) begin
      fails++; $display("FAIL clr_pre got=%h/%h/%b exp=%h/55/1", acc_out, out_data, out_valid, acc_exp(8'hAA));
    end
    acc_clr = 1'b1;
    @(negedge clk);
    tests++; if (acc_out !== acc_exp(8'h55)) begin fails++; $display("FAIL clr_accept got=%h exp=%h", acc_out, acc_exp(8'h55)); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_idle got=%b exp=0", out_valid); end
    @(negedge clk);
    acc_clr = 1'b0;
    tests++; if (acc_out !== 8'h00) begin fails++; $display("FAIL clr_only got=%h exp=00", acc_out); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    beat(2'b00, 8'h5A, 8'h00);
    beat(2'b00, 8'h11, 8'h00);
    beat(2'b00, 8'h22, 8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    tests++; if (acc_out !== acc_exp(8'h5A) || out_data !== 8'h11 || out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got=%h/%h/%b exp=%h/11/1", acc_out, out_data, out_valid, acc_exp(8'h5A));
    end
    resetn = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || acc_out !== 8'h00 || in_ready !== 1'b1) begin
      fails++; $display("FAIL mid_async got=%b/%h/%h/%b exp=0/00/00/1", out_valid, out_data, acc_out, in_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || acc_out !== 8'h00) begin
        fails++; $display("FAIL mid_after%0d got=%b/%h exp=0/00", i, out_valid, acc_out);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] acc_m;
    logic [7:0] prev_d;
    logic       prev_stall;
    logic       exp_adv;
    int         sent;
    int         got;
    do_reset();
    acc_m = 8'h00; prev_stall = 1'b0; prev_d = 8'h00; sent = 0; got = 0;
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        tests++; if (out_valid !== 1'b1 || out_data !== prev_d) begin
          fails++; $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, prev_d);
        end
      end
      a = 8'($urandom); b = 8'($urandom); op = 2'(cyc % 4);
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests++; if (out_comb !== ref_op(op, a, b)) begin
        fails++; $display("FAIL rnd_comb cyc=%0d got=%h exp=%h", cyc, out_comb, ref_op(op, a, b));
      end
      exp_adv = !out_valid || out_ready;
      tests++; if (in_ready !== exp_adv) begin
        fails++; $display("FAIL rnd_iready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_adv);
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_extra cyc=%0d got=%h exp=none", cyc, out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin
            fails++; $display("FAIL rnd_data beat=%0d got=%h exp=%h", got, out_data, exp_d);
          end
          acc_m = acc_m ^ exp_d;
          got++;
        end
      end
      if (in_valid && exp_adv) begin
        q.push_back(ref_op(op, a, b));
        sent++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_d     = out_data;
    end
    tests++; if (got != 200) begin fails++; $display("FAIL rnd_count got=%0d exp=200", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rnd_drain got=%b exp=0", out_valid); end
    tests++; if (acc_out !== acc_exp(acc_m)) begin fails++; $display("FAIL rnd_acc got=%h exp=%h", acc_out, acc_exp(acc_m)); end
  endtask

  initial begin
    tests = 0; fails = 0;
    resetn = 1'b0; a = 8'h00; b = 8'h00; op = 2'b00;
    in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    test_reset();
    test_comb();
    test_latency();
    test_stall();
    test_acc_clr();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitwise_op_pipe.md
BITWISE_OP_PIPE -- requirements
Module: bitwise_op_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages from input beat to output beat, legal range 1..8.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port resetn, input, 1, one clock; reset is asynchronous and active-low.
REQ-005 Port a, input, WIDTH, operand A.
REQ-006 Port b, input, WIDTH, operand B.
REQ-007 Port op, input, 2, operation select: 00 XOR, 01 XNOR, 10 AND, 11 OR.
REQ-008 Port in_valid, input, 1, input beat present.
REQ-009 Port in_ready, output, 1, block accepts input beat this cycle.
REQ-010 Port out_comb, output, WIDTH, combinational op(a,b), independent of handshake.
REQ-011 Port out_data, output, WIDTH, registered result of the beat at pipeline head.
REQ-012 Port out_valid, output, 1, out_data holds a valid beat.
REQ-013 Port out_ready, input, 1, downstream accepts the output beat.
REQ-014 Port acc_clr, input, 1, synchronous accumulator clear.
REQ-015 Port acc_out, output, WIDTH, running XOR of accepted output beats.

Function
REQ-016 out_comb SHALL equal op applied bitwise to a and b in the same cycle, with zero latency and no dependence on clk or resetn.
REQ-017 Input handshake: a beat is accepted when in_valid && in_ready; op SHALL be sampled together with a and b.
REQ-018 The pipeline SHALL carry DEPTH stages of {valid, data}; stage 0 captures op(a,b) of the accepted beat, or valid=0 when no beat is accepted.
REQ-019 Advance = !out_valid || out_ready; all stages shift together when advance=1 and hold all contents when advance=0.
REQ-020 in_ready SHALL equal advance (combinational, out_ready to in_ready path permitted).
REQ-021 Latency: a beat accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+DEPTH when no stall occurs; each stall cycle adds one cycle.
REQ-022 Throughput SHALL be one beat per cycle when out_ready is held at 1; beats SHALL never be dropped, duplicated or reordered.
REQ-023 out_data and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Bubbles (invalid stages) SHALL propagate as bubbles; the pipeline does not collapse them.
REQ-025 Output acceptance is out_valid && out_ready; on acceptance acc_out <= acc_out ^ out_data.
REQ-026 acc_clr=1 without acceptance SHALL set acc_out to 0; acc_clr=1 with simultaneous acceptance SHALL set acc_out to that cycle's out_data.
REQ-027 acc_out SHALL wrap naturally; it is a bitwise XOR and has no overflow condition.

Reset
REQ-028 While resetn=0: all stage valid bits = 0, stage data = 0, out_valid = 0, out_data = 0, acc_out = 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats immediately with no output beat emitted.
REQ-030 in_ready SHALL be 1 during reset and in the first cycle after release.

Configuration
REQ-031 Macro BITWISE_OP_PIPE_ACCUM_EN defined: the accumulator of REQ-025..027 is compiled in.
REQ-032 Macro BITWISE_OP_PIPE_ACCUM_EN undefined: no accumulator register exists, acc_out SHALL be constant 0, and acc_clr SHALL be ignored; all other behaviour is unchanged.

Verification (WIDTH=8, DEPTH=2, macro defined)
REQ-033 Reset release, a=0x0F, b=0x3C, op=00, in_valid=0 -> out_comb=0x33, out_valid=0, out_data=0x00, acc_out=0x00, in_ready=1.
REQ-034 Beats with op=00 and (a,b) = (0x0F,0x3C), (0xFF,0x01), out_ready=1 -> out_data=0x33 in cycle N+2 and 0xFE in cycle N+3; acc_out then 0x33, then 0xCD.
REQ-035 One beat with op=10 (0xF0,0x3C) then one with op=11 (0xF0,0x3C), out_ready=0 for 3 cycles -> out_data holds 0x30 with out_valid=1 and in_ready=0; after out_ready=1, outputs 0x30 then 0xFC in order.
REQ-036 acc_clr=1 in the same cycle as acceptance of 0x55 while acc_out=0xAA -> acc_out=0x55; acc_clr=1 with no acceptance -> acc_out=0x00.
REQ-037 resetn pulsed low while 2 beats are in flight -> out_valid=0 immediately, no beat emitted after release, acc_out=0x00.
REQ-038 Exhaustive 2-bit op sweep over all 4 values with random a/b for 200 beats under random out_ready -> out_data matches the reference model in order, and out_comb matches every cycle.
